// File: rtl/dm_access_pkg.sv
// Shared op codes, FSM encoding and op classification helpers for the data-memory access controller.
package dm_access_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4,
    OP_SW  = 3'd5,
    OP_SB  = 3'd6,
    OP_SH  = 3'd7
  } dm_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } dm_state_e;

  function automatic logic is_store(input dm_op_e op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_half(input dm_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input dm_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load data formatter: turns the captured word / byte pair into the architectural load result.
module dm_load_ext
  import dm_access_pkg::*;
(
  input  dm_op_e      op,
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = 32'd0;
    case (op)
      OP_LW:   rdata = word;
      OP_LB:   rdata = {{24{byte0[7]}}, byte0};
      OP_LBU:  rdata = {24'd0, byte0};
      // byte0 came from the lower address, so it is the low half
      OP_LH:   rdata = {{16{byte1[7]}}, byte1, byte0};
      OP_LHU:  rdata = {16'd0, byte1, byte0};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer for the 4 KB data memory: checks, issues word/byte accesses, extends loads.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int DM_AW       = 10,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  output logic             dm_bmode,
  output logic [1:0]       dm_bsel,
  input  logic [31:0]      dm_dout
);

  dm_state_e        state_q, state_d;
  dm_op_e           op_q, op_d;
  logic [DM_AW+1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [7:0]       b0_q, b0_d, b1_q, b1_d;
  logic [31:0]      word_q, word_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  dm_op_e      req_op_e;
  logic        req_bad;
  logic [7:0]  ext_b0, ext_b1;
  logic [31:0] ext_word, ext_rdata;

  assign req_op_e = dm_op_e'(req_op);
  assign req_bad  = (is_word(req_op_e) && (req_addr[1:0] != 2'd0))
                  || (is_half(req_op_e) && req_addr[0])
                  || (CHECK_RANGE && ((req_addr >> (DM_AW + 2)) != 32'd0));

  // The byte read in the final access cycle is forwarded so the result is ready on entry to RESP.
  assign ext_b0   = (state_q == ST_ACC0) ? dm_dout[7:0] : b0_q;
  assign ext_b1   = (state_q == ST_ACC1) ? dm_dout[7:0] : b1_q;
  assign ext_word = (state_q == ST_ACC0) ? dm_dout      : word_q;

  dm_load_ext u_load_ext (
    .op    (op_q),
    .byte0 (ext_b0),
    .byte1 (ext_b1),
    .word  (ext_word),
    .rdata (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    word_d      = word_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op_e;
          addr_d  = req_addr[DM_AW+1:0];
          wdata_d = req_wdata;
          if (req_bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d = ST_ACC0;
          end
        end
      end
      ST_ACC0: begin
        if (!is_store(op_q)) begin
          word_d = dm_dout;
          b0_d   = dm_dout[7:0];
        end
        if (is_half(op_q)) begin
          state_d = ST_ACC1;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = is_store(op_q) ? 32'd0 : ext_rdata;
        end
      end
      ST_ACC1: begin
        if (!is_store(op_q)) b1_d = dm_dout[7:0];
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = is_store(op_q) ? 32'd0 : ext_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dm_addr   = addr_q[DM_AW+1:2];

  // Memory port is a pure decode of registered state so reset kills dm_we asynchronously.
  always_comb begin
    dm_we    = 1'b0;
    dm_bmode = 1'b0;
    dm_bsel  = 2'd0;
    dm_din   = 32'd0;
    case (state_q)
      ST_ACC0: begin
        dm_we = is_store(op_q);
        if (is_word(op_q)) begin
          dm_din = wdata_q;
        end else begin
          dm_bmode = 1'b1;
          dm_bsel  = addr_q[1:0];
          dm_din   = {24'd0, wdata_q[7:0]};
        end
      end
      ST_ACC1: begin
        dm_we    = is_store(op_q);
        dm_bmode = 1'b1;
        dm_bsel  = addr_q[1:0] + 2'd1;
        dm_din   = {24'd0, wdata_q[15:8]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench: controller plus behavioural 4 KB memory, directed requests checked by a response scoreboard.
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we, dm_bmode;
  logic [1:0]  dm_bsel;

  dm_access_ctrl #(.DM_AW(10), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_bmode(dm_bmode), .dm_bsel(dm_bsel), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: posedge write, combinational read, byte mode returns sign-extended lane.
  bit [7:0] mem [4096];
  always @(posedge clk) begin
    if (dm_we) begin
      if (dm_bmode) mem[{dm_addr, dm_bsel}] <= dm_din[7:0];
      else for (int k = 0; k < 4; k++) mem[{dm_addr, 2'(k)}] <= dm_din[8*k +: 8];
    end
  end
  always_comb begin
    dm_dout = 32'd0;
    if (dm_bmode) dm_dout = {{24{mem[{dm_addr, dm_bsel}][7]}}, mem[{dm_addr, dm_bsel}]};
    else dm_dout = {mem[{dm_addr, 2'd3}], mem[{dm_addr, 2'd2}], mem[{dm_addr, 2'd1}], mem[{dm_addr, 2'd0}]};
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] bsel_log[$];
  int checks = 0, failures = 0, cyc = 0, we_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response and tracks memory write pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_we) begin
        we_cnt++;
        bsel_log.push_back(dm_bsel);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  // lat: cycles from accept edge to the cycle in which rsp_valid is high.
  task automatic issue(input dm_op_e op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    exp_q.push_back('{er, ee, cyc + lat - 1});
    @(negedge clk);
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    int w0, a;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_dm_port", {dm_we, dm_bmode, dm_bsel, 2'd0, dm_addr}, 32'd0);
    chk("rst_dm_din", dm_din, 32'd0);
    chk("rst_rsp", {rsp_err, rsp_rdata[30:0]} | {31'd0, rsp_rdata[31]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store / load
    issue(OP_SW, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    chk("mem_word4", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEADBEEF);
    issue(OP_LW, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store, signed / unsigned byte loads
    issue(OP_SB, 32'h13, 32'h12345680, 32'd0, 1'b0, 2);
    chk("mem_sb_lanes", {mem[19], mem[18], mem[17], mem[16]}, 32'h80ADBEEF);
    issue(OP_LB, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 2);
    issue(OP_LBU, 32'h13, 32'd0, 32'h00000080, 1'b0, 2);
    issue(OP_LB, 32'h11, 32'd0, 32'hFFFFFFBE, 1'b0, 2);

    // Halfword store as two byte writes, then halfword loads
    bsel_log.delete();
    w0 = we_cnt;
    issue(OP_SH, 32'h22, 32'hAAAA8123, 32'd0, 1'b0, 3);
    chk("sh_we_pulses", we_cnt - w0, 32'd2);
    chk("sh_bsel_seq", {28'd0, bsel_log[0], bsel_log[1]}, 32'hB);
    chk("mem_sh_bytes", {8'd0, mem[35], mem[34], mem[33]}, 32'h00812300);
    issue(OP_LH, 32'h22, 32'd0, 32'hFFFF8123, 1'b0, 3);
    issue(OP_LHU, 32'h22, 32'd0, 32'h00008123, 1'b0, 3);

    // Misaligned and out-of-range requests
    w0 = we_cnt;
    issue(OP_SW, 32'h06, 32'h55555555, 32'd0, 1'b1, 1);
    issue(OP_LH, 32'h01, 32'd0, 32'd0, 1'b1, 1);
    issue(OP_SW, 32'h1000, 32'h66666666, 32'd0, 1'b1, 1);
    chk("err_no_we", we_cnt - w0, 32'd0);
    chk("err_mem_untouched", {mem[7], mem[6], mem[5], mem[4]}, 32'd0);

    // req_valid held through a busy load: second accepted only once ready returns
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk);
    #1;
    a = cyc;
    exp_q.push_back('{32'h80ADBEEF, 1'b0, a + 1});
    exp_q.push_back('{32'h80ADBEEF, 1'b0, a + 4});
    @(negedge clk);
    chk("busy_ready_acc0", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("busy_ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_returns", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Reset in the middle of a halfword store
    issue(OP_SW, 32'h30, 32'h11223344, 32'd0, 1'b0, 2);
    issue(OP_LW, 32'h30, 32'd0, 32'h11223344, 1'b0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h30; req_wdata = 32'h0000A5B6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", {31'd0, dm_we}, 32'd0);
    chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("rstmid_bytes", {16'd0, mem[49], mem[48]}, 32'h000033B6);
    rst_n = 1'b1;
    issue(OP_LW, 32'h30, 32'd0, 32'h112233B6, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
